// File: rtl/fakeram7_arb_pkg.sv
// Shared types for the fakeram7 dual-port arbiter: default macro geometry and
// the per-port grant record that drives one side of the RAM.
package fakeram7_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_BITS       = 32;
    localparam int MAX_NREQ       = 8;
    localparam int IDX_W          = $clog2(MAX_NREQ);

    typedef struct packed {
        logic                      vld;
        logic [IDX_W-1:0]          idx;
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_BITS-1:0]       wd;
        logic [DEF_BITS-1:0]       wmask;
    } arb_grant_t;

endpackage

// File: rtl/fakeram7_rr_pick.sv
// Rotating priority encoder: first eligible requester at or after ptr_i,
// wrapping modulo NREQ, ignoring anything set in skip_i.
module fakeram7_rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [NREQ-1:0]  skip_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             vld_o
);

    logic [NREQ-1:0] elig;

    assign elig = req_i & ~skip_i;

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        int cand;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!vld_o && elig[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = PTR_W'(cand);
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fakeram7_dp_arbiter.sv
// Round-robin arbiter sharing one fakeram7_dp_2048x32 macro between NREQ
// requesters: up to two grants per cycle, hazard blocking, 1-cycle responses.
module fakeram7_dp_arbiter
    import fakeram7_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BITS       = DEF_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*BITS-1:0]       req_wdata,
    input  logic [NREQ*BITS-1:0]       req_wmask,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [NREQ*BITS-1:0]       rsp_rdata,
    output logic                       ram_ce,
    output logic                       ram_we_A,
    output logic                       ram_we_B,
    output logic [ADDR_WIDTH-1:0]      ram_addr_A,
    output logic [ADDR_WIDTH-1:0]      ram_addr_B,
    output logic [BITS-1:0]            ram_wd_A,
    output logic [BITS-1:0]            ram_wd_B,
    output logic [BITS-1:0]            ram_wmask_A,
    output logic [BITS-1:0]            ram_wmask_B,
    input  logic [BITS-1:0]            ram_rd_A,
    input  logic [BITS-1:0]            ram_rd_B
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             vld_a_q, vld_a_d, vld_b_q, vld_b_d;
    logic [NREQ-1:0]  own_a_q, own_b_q;

    logic [NREQ-1:0]  req_act, conflict, skip_b;
    logic [NREQ-1:0]  gnt_a, gnt_b;
    logic [PTR_W-1:0] idx_a, idx_b;
    logic             a_vld, b_vld;
    arb_grant_t       port_a, port_b;
    logic [IDX_W-1:0] last_idx, next_idx;

    assign req_act = req_valid & {NREQ{~rst}};

    fakeram7_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_a (
        .req_i (req_act),
        .ptr_i (ptr_q),
        .skip_i('0),
        .gnt_o (gnt_a),
        .idx_o (idx_a),
        .vld_o (a_vld)
    );

    // Port B may not touch port A's address if either side writes; read/read is fine.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NREQ; i++) begin
            conflict[i] = a_vld && (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == port_a.addr)
                          && (req_we[i] || port_a.we);
        end
    end

    assign skip_b = gnt_a | conflict;

    fakeram7_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_b (
        .req_i (req_act),
        .ptr_i (ptr_q),
        .skip_i(skip_b),
        .gnt_o (gnt_b),
        .idx_o (idx_b),
        .vld_o (b_vld)
    );

    // An ungranted port stays all-zero so no X reaches the macro while ce is high.
    always_comb begin
        port_a = '0;
        port_b = '0;
        if (a_vld) begin
            port_a.vld   = 1'b1;
            port_a.idx   = IDX_W'(idx_a);
            port_a.we    = req_we[idx_a];
            port_a.addr  = req_addr[idx_a*ADDR_WIDTH +: ADDR_WIDTH];
            port_a.wd    = req_wdata[idx_a*BITS +: BITS];
            port_a.wmask = req_wmask[idx_a*BITS +: BITS];
        end
        if (b_vld) begin
            port_b.vld   = 1'b1;
            port_b.idx   = IDX_W'(idx_b);
            port_b.we    = req_we[idx_b];
            port_b.addr  = req_addr[idx_b*ADDR_WIDTH +: ADDR_WIDTH];
            port_b.wd    = req_wdata[idx_b*BITS +: BITS];
            port_b.wmask = req_wmask[idx_b*BITS +: BITS];
        end
    end

    assign req_ready   = gnt_a | gnt_b;
    assign ram_ce      = port_a.vld;
    assign ram_we_A    = port_a.we;
    assign ram_addr_A  = port_a.addr;
    assign ram_wd_A    = port_a.wd;
    assign ram_wmask_A = port_a.wmask;
    assign ram_we_B    = port_b.we;
    assign ram_addr_B  = port_b.addr;
    assign ram_wd_B    = port_b.wd;
    assign ram_wmask_B = port_b.wmask;

    always_comb begin
        last_idx = port_b.vld ? port_b.idx : port_a.idx;
        next_idx = (last_idx == IDX_W'(NREQ-1)) ? '0 : last_idx + 1'b1;
        ptr_d    = port_a.vld ? PTR_W'(next_idx) : ptr_q;
        vld_a_d  = port_a.vld;
        vld_b_d  = port_b.vld;
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
        end
    end

    // NOTE: owner registers carry no reset; they are only ever looked at
    // through the valid bits, which are reset.
    always_ff @(posedge clk) begin
        own_a_q <= gnt_a;
        own_b_q <= gnt_b;
    end

    // Responses are gated by rst so an in-flight read is dropped immediately.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rst && vld_a_q && own_a_q[i]) begin
                rsp_valid[i]              = 1'b1;
                rsp_rdata[i*BITS +: BITS] = ram_rd_A;
            end else if (!rst && vld_b_q && own_b_q[i]) begin
                rsp_valid[i]              = 1'b1;
                rsp_rdata[i*BITS +: BITS] = ram_rd_B;
            end
        end
    end

endmodule

// File: tb/tb_fakeram7_dp_arbiter.sv
// Directed bench for fakeram7_dp_arbiter with a behavioural dual-port macro
// (registered read, read-old-data, per-bit write mask).
module tb_fakeram7_dp_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 11;
    localparam int BW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*BW-1:0] req_wdata, req_wmask, rsp_rdata;
    logic               ram_ce, ram_we_A, ram_we_B;
    logic [AW-1:0]      ram_addr_A, ram_addr_B;
    logic [BW-1:0]      ram_wd_A, ram_wd_B, ram_wmask_A, ram_wmask_B;
    logic [BW-1:0]      ram_rd_A, ram_rd_B;

    int n_checks = 0;
    int n_errors = 0;
    int cnt [NREQ];

    fakeram7_dp_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .BITS(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_ce     (ram_ce),
        .ram_we_A   (ram_we_A),
        .ram_we_B   (ram_we_B),
        .ram_addr_A (ram_addr_A),
        .ram_addr_B (ram_addr_B),
        .ram_wd_A   (ram_wd_A),
        .ram_wd_B   (ram_wd_B),
        .ram_wmask_A(ram_wmask_A),
        .ram_wmask_B(ram_wmask_B),
        .ram_rd_A   (ram_rd_A),
        .ram_rd_B   (ram_rd_B)
    );

    always #5 clk = ~clk;

    // Behavioural macro; contents preloaded on the first edge.
    logic [BW-1:0] mem [0:2047];
    logic          loaded = 1'b0;

    function automatic logic [BW-1:0] init_val(input int a);
        case (a)
            'h001:   return 32'h1111_1111;
            'h7FF:   return 32'h7777_7777;
            'h020:   return 32'h2020_2020;
            'h030:   return 32'h3030_3030;
            'h040:   return 32'h1234_5678;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_ce) begin
            ram_rd_A <= mem[ram_addr_A];
            ram_rd_B <= mem[ram_addr_B];
            if (ram_we_A) mem[ram_addr_A] <= (mem[ram_addr_A] & ~ram_wmask_A) | (ram_wd_A & ram_wmask_A);
            if (ram_we_B) mem[ram_addr_B] <= (mem[ram_addr_B] & ~ram_wmask_B) | (ram_wd_B & ram_wmask_B);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [BW-1:0] wd, input logic [BW-1:0] wm);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = addr;
        req_wdata[i*BW +: BW] = wd;
        req_wmask[i*BW +: BW] = wm;
    endtask

    task automatic drop_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0, '0);
        next_cycle();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_ce", ram_ce, 1'b0);
        check("rst_addr_A", ram_addr_A, 0);
        check("rst_we_A", ram_we_A, 1'b0);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_rsp_rdata", rsp_rdata, 0);
        next_cycle();
        rst = 1'b0;
        clear_reqs();

        // Single writer then reader on requester 2 (ptr 0 -> 3 -> 3)
        set_req(2, 1'b1, 11'h010, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        #1;
        check("wr_ready", req_ready, 4'b0100);
        check("wr_ce", ram_ce, 1'b1);
        check("wr_we_A", ram_we_A, 1'b1);
        check("wr_addr_A", ram_addr_A, 11'h010);
        check("wr_wd_A", ram_wd_A, 32'hDEAD_BEEF);
        check("wr_idle_B", {ram_we_B, ram_addr_B, ram_wmask_B}, 0);
        next_cycle();
        clear_reqs();
        check("wr_rsp_valid", rsp_valid, 4'b0100);
        check("wr_rsp_old", rsp_rdata[2*BW +: BW], 32'h0);
        set_req(2, 1'b0, 11'h010, '0, '0);
        #1;
        check("rd_ready", req_ready, 4'b0100);
        check("rd_we_A", ram_we_A, 1'b0);
        next_cycle();
        clear_reqs();
        #1;
        check("rd_rsp_valid", rsp_valid, 4'b0100);
        check("rd_rsp_data", rsp_rdata[2*BW +: BW], 32'hDEAD_BEEF);
        check("rd_ce_low", ram_ce, 1'b0);

        // Dual grant, ptr 3: A = req0, B = req1
        set_req(0, 1'b0, 11'h001, '0, '0);
        set_req(1, 1'b0, 11'h7FF, '0, '0);
        #1;
        check("dual_ready", req_ready, 4'b0011);
        check("dual_addr_A", ram_addr_A, 11'h001);
        check("dual_addr_B", ram_addr_B, 11'h7FF);
        next_cycle();
        clear_reqs();
        check("dual_rsp_valid", rsp_valid, 4'b0011);
        check("dual_rsp0", rsp_rdata[0*BW +: BW], 32'h1111_1111);
        check("dual_rsp1", rsp_rdata[1*BW +: BW], 32'h7777_7777);

        // Requester 3 alone moves ptr 2 -> 0
        set_req(3, 1'b0, 11'h030, '0, '0);
        #1;
        check("r3_ready", req_ready, 4'b1000);
        next_cycle();
        clear_reqs();
        check("r3_rsp", rsp_rdata[3*BW +: BW], 32'h3030_3030);

        // Conflict: req1 blocked by req0's write to the same word
        set_req(0, 1'b1, 11'h020, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        set_req(1, 1'b0, 11'h020, '0, '0);
        set_req(2, 1'b0, 11'h030, '0, '0);
        #1;
        check("cf_ready", req_ready, 4'b0101);
        check("cf_addr_A", ram_addr_A, 11'h020);
        check("cf_we_A", ram_we_A, 1'b1);
        check("cf_addr_B", ram_addr_B, 11'h030);
        next_cycle();
        drop_req(0);
        drop_req(2);
        #1;
        check("cf_rsp_valid", rsp_valid, 4'b0101);
        check("cf_rsp0_old", rsp_rdata[0*BW +: BW], 32'h2020_2020);
        check("cf_rsp2", rsp_rdata[2*BW +: BW], 32'h3030_3030);
        check("cf_retry_ready", req_ready, 4'b0010);
        next_cycle();
        clear_reqs();
        check("cf_retry_valid", rsp_valid, 4'b0010);
        check("cf_retry_data", rsp_rdata[1*BW +: BW], 32'hA5A5_A5A5);

        // ptr 2 -> 0 again before fairness run
        set_req(3, 1'b0, 11'h030, '0, '0);
        #1;
        check("r3b_ready", req_ready, 4'b1000);
        next_cycle();
        clear_reqs();

        // Fairness: all four valid for 8 cycles
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            set_req(i, 1'b0, AW'('h100 + i), '0, '0);
        end
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("fair_ready_%0d", c), req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < NREQ; i++) cnt[i] += int'(req_ready[i]);
            next_cycle();
        end
        clear_reqs();
        for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt_%0d", i), cnt[i], 4);

        // Masked write over 0x12345678, then read back (ptr 0 -> 2 -> 2)
        set_req(1, 1'b1, 11'h040, 32'hFFFF_FFFF, 32'h0000_FF00);
        #1;
        check("mw_ready", req_ready, 4'b0010);
        check("mw_wmask_A", ram_wmask_A, 32'h0000_FF00);
        next_cycle();
        clear_reqs();
        check("mw_rsp_old", rsp_rdata[1*BW +: BW], 32'h1234_5678);
        set_req(1, 1'b0, 11'h040, '0, '0);
        next_cycle();
        clear_reqs();
        check("mw_readback", rsp_rdata[1*BW +: BW], 32'h1234_FF78);

        // Reset with a read in flight (ptr 2 -> 3, then reset to 0)
        set_req(2, 1'b0, 11'h010, '0, '0);
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'('h200 + i), '0, '0);
        #1;
        check("mr_rsp_valid", rsp_valid, 4'b0000);
        check("mr_rsp_rdata", rsp_rdata, 0);
        check("mr_ready", req_ready, 4'b0000);
        check("mr_ce", ram_ce, 1'b0);
        next_cycle();
        check("mr_rsp_after", rsp_valid, 4'b0000);
        rst = 1'b0;
        #1;
        check("mr_first_ready", req_ready, 4'b0011);
        check("mr_first_addr_A", ram_addr_A, 11'h200);
        next_cycle();
        clear_reqs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
